bist_and_datapath: RTL and testbench



---
 rtl/bist_and_pkg.sv | 21 ++
 rtl/bist_and_datapath_if.sv | 22 ++
 rtl/bist_sisr.sv | 38 +++
 rtl/bist_and_datapath.sv | 109 ++++++++++
 tb/tb_bist_and_datapath.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bist_and_pkg.sv
// Shared constants for the AND-gate BIST datapath: SISR geometry, golden signature,
// run length and fault-select encodings.
package bist_and_pkg;

  localparam int unsigned SIG_W     = 4;
  localparam int unsigned TPG_W     = 2;
  localparam int unsigned PAT_CNT_W = 3;
  localparam int unsigned NPAT      = 4;

  localparam logic [SIG_W-1:0] SEED   = 4'hA;
  localparam logic [SIG_W-1:0] GOLDEN = 4'hE;

  // Feedback taps sig[3] and sig[2]
  localparam logic [SIG_W-1:0] SISR_TAPS = 4'b1100;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_OUT_SA0 = 2'b01;
  localparam logic [1:0] FAULT_OUT_SA1 = 2'b10;
  localparam logic [1:0] FAULT_A_SA0   = 2'b11;

endpackage

// File: rtl/bist_and_datapath_if.sv
// Controller <-> BIST datapath strobes and status.
interface bist_and_if;
  import bist_and_pkg::*;

  logic             init;
  logic             en;
  logic             compare;
  logic             result;
  logic [SIG_W-1:0] sig;
  logic             bist_done;
  logic             bist_pass;

  modport master (
    output init, en, compare,
    input  result, sig, bist_done, bist_pass
  );

  modport slave (
    input  init, en, compare,
    output result, sig, bist_done, bist_pass
  );
endinterface

// File: rtl/bist_sisr.sv
// Serial-input signature register: shifts left, feeding back XOR of tapped bits and din.
module bist_sisr #(
  parameter int unsigned  W    = 4,
  parameter logic [W-1:0] SEED = '0,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q, sig_d;
  logic         fb;

  always_comb begin
    fb    = (^(sig_q & TAPS)) ^ din_i;
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[W-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_and_datapath.sv
// AND-gate BIST datapath: TPG, CUT with functional/test mux, SISR and golden compare.
// Optional BIST_FAULT_INJECT_EN adds fault_sel for injecting CUT faults.
module bist_and_datapath
  import bist_and_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  bist_and_if.slave bus,
  input  logic     func_a,
  input  logic     func_b,
  output logic     and_out
`ifdef BIST_FAULT_INJECT_EN
  ,
  input  logic [1:0] fault_sel
`endif
);

  localparam logic [PAT_CNT_W-1:0] PAT_MAX = '1;

  logic [TPG_W-1:0]     tpg_q, tpg_d;
  logic [PAT_CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 cut_a, cut_b, cut_y;
  logic [SIG_W-1:0]     sig;
  logic                 result;
  logic                 step;

  // init outranks en, so a simultaneous strobe applies no pattern
  assign step = bus.en & ~bus.init;

  // CUT input mux and the AND gate itself, with optional fault overlay
  always_comb begin
    cut_a = bus.en ? tpg_q[1] : func_a;
    cut_b = bus.en ? tpg_q[0] : func_b;
`ifdef BIST_FAULT_INJECT_EN
    if (fault_sel == FAULT_A_SA0) begin
      cut_a = 1'b0;
    end
    cut_y = cut_a & cut_b;
    if (fault_sel == FAULT_OUT_SA0) begin
      cut_y = 1'b0;
    end else if (fault_sel == FAULT_OUT_SA1) begin
      cut_y = 1'b1;
    end
`else
    cut_y = cut_a & cut_b;
`endif
  end

  assign and_out = cut_y;

  bist_sisr #(
    .W    (SIG_W),
    .SEED (SEED),
    .TAPS (SISR_TAPS)
  ) u_sisr (
    .clk    (clk),
    .rst    (rst),
    .load_i (bus.init),
    .en_i   (step),
    .din_i  (cut_y),
    .sig_o  (sig)
  );

  assign result = (sig == GOLDEN) && (pat_cnt_q == PAT_CNT_W'(NPAT));

  always_comb begin
    tpg_d     = tpg_q;
    pat_cnt_d = pat_cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    if (bus.init) begin
      tpg_d     = '0;
      pat_cnt_d = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end else if (bus.en) begin
      tpg_d = tpg_q + TPG_W'(1);
      // Saturating count makes an over-long run fail the compare
      if (pat_cnt_q != PAT_MAX) begin
        pat_cnt_d = pat_cnt_q + PAT_CNT_W'(1);
      end
    end else if (bus.compare) begin
      done_d = 1'b1;
      pass_d = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tpg_q     <= '0;
      pat_cnt_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      tpg_q     <= tpg_d;
      pat_cnt_q <= pat_cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.result    = result;
  assign bus.sig       = sig;
  assign bus.bist_done = done_q;
  assign bus.bist_pass = pass_q;

endmodule

// File: tb/tb_bist_and_datapath.sv
// Scoreboard bench for bist_and_datapath; fault scenarios run when BIST_FAULT_INJECT_EN is defined.
module tb_bist_and_datapath;
  import bist_and_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic func_a, func_b;
  logic and_out;
`ifdef BIST_FAULT_INJECT_EN
  logic [1:0] fault_sel;
`endif

  bist_and_if bus();

  bist_and_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .func_a  (func_a),
    .func_b  (func_b),
    .and_out (and_out)
`ifdef BIST_FAULT_INJECT_EN
    ,
    .fault_sel (fault_sel)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [3:0] sb_q[$];
  logic [3:0] m_sig;
  logic [1:0] m_tpg;
  logic [1:0] m_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_y();
    logic a, b;
    a = m_tpg[1];
    b = m_tpg[0];
    case (m_fault)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return 1'b0;
      default: return a & b;
    endcase
  endfunction

  // One clock cycle of controller strobes; called and returns at a falling edge
  task automatic cycle(input logic i, input logic e, input logic c);
    logic y;
    bus.init    = i;
    bus.en      = e;
    bus.compare = c;
    if (i) begin
      m_sig = 4'hA;
      m_tpg = 2'd0;
    end else if (e) begin
      y = model_y();
      #1 check_eq("and_out_tpg", 32'(and_out), 32'(y));
      m_sig = {m_sig[2:0], m_sig[3] ^ m_sig[2] ^ y};
      m_tpg = m_tpg + 2'd1;
      sb_q.push_back(m_sig);
    end
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) check_eq("sig_step", 32'(bus.sig), 32'(sb_q.pop_front()));
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.init    = 1'b0;
    bus.en      = 1'b0;
    bus.compare = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_sig = 4'hA;
    m_tpg = 2'd0;
    sb_q.delete();
  endtask

  task automatic full_run(input int n_en);
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < n_en; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    func_a = 1'b1;
    func_b = 1'b1;
    bus.init = 1'b0;
    bus.en = 1'b0;
    bus.compare = 1'b0;
    m_fault = 2'b00;
`ifdef BIST_FAULT_INJECT_EN
    fault_sel = 2'b00;
`endif
    @(negedge clk);
    do_reset();

    // Reset state and functional path
    check_eq("rst_sig", 32'(bus.sig), 32'h0000_000A);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_done", 32'(bus.bist_done), 32'd0);
    check_eq("rst_pass", 32'(bus.bist_pass), 32'd0);
    check_eq("func_11", 32'(and_out), 32'd1);
    func_b = 1'b0;
    #1 check_eq("func_10", 32'(and_out), 32'd0);
    func_b = 1'b1;
    @(negedge clk);

    // Fault-free 4-pattern run: A,5,B,7,E
    full_run(4);
    check_eq("ff_sig", 32'(bus.sig), 32'h0000_000E);
    check_eq("ff_result", 32'(bus.result), 32'd1);
    check_eq("ff_done_pre", 32'(bus.bist_done), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("ff_done", 32'(bus.bist_done), 32'd1);
    check_eq("ff_pass", 32'(bus.bist_pass), 32'd1);

    // Over-long run of 5 patterns fails
    full_run(5);
    check_eq("long_cnt", 32'(dut.pat_cnt_q), 32'd5);
    check_eq("long_result", 32'(bus.result), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("long_done", 32'(bus.bist_done), 32'd1);
    check_eq("long_pass", 32'(bus.bist_pass), 32'd0);

    // init together with en: first pattern suppressed
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("ie_sig", 32'(bus.sig), 32'h0000_000A);
    check_eq("ie_done", 32'(bus.bist_done), 32'd0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0);
    check_eq("ie_final", 32'(bus.sig), 32'h0000_000E);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("ie_pass", 32'(bus.bist_pass), 32'd1);

    // Gap mid-run; compare during en is ignored
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("gap_cmp_ignored", 32'(bus.bist_done), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("gap_hold_sig", 32'(bus.sig), 32'h0000_000B);
    check_eq("gap_result", 32'(bus.result), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_eq("gap_final", 32'(bus.sig), 32'h0000_000E);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("gap_pass", 32'(bus.bist_pass), 32'd1);

    // Reset mid-run discards everything
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("mr_done_pre", 32'(bus.bist_done), 32'd1);
    do_reset();
    check_eq("mr_sig", 32'(bus.sig), 32'h0000_000A);
    check_eq("mr_cnt", 32'(dut.pat_cnt_q), 32'd0);
    check_eq("mr_done", 32'(bus.bist_done), 32'd0);
    check_eq("mr_and", 32'(and_out), 32'd1);

`ifdef BIST_FAULT_INJECT_EN
    // Output stuck-at-0
    fault_sel = 2'b01; m_fault = 2'b01;
    full_run(4);
    check_eq("sa0_sig", 32'(bus.sig), 32'h0000_000F);
    check_eq("sa0_result", 32'(bus.result), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("sa0_pass", 32'(bus.bist_pass), 32'd0);

    // Output stuck-at-1: 4,8,0,1
    fault_sel = 2'b10; m_fault = 2'b10;
    full_run(4);
    check_eq("sa1_sig", 32'(bus.sig), 32'h0000_0001);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("sa1_pass", 32'(bus.bist_pass), 32'd0);

    // Input a stuck-at-0, also visible in functional mode
    fault_sel = 2'b11; m_fault = 2'b11;
    #1 check_eq("asa0_func", 32'(and_out), 32'd0);
    full_run(4);
    check_eq("asa0_sig", 32'(bus.sig), 32'h0000_000F);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("asa0_pass", 32'(bus.bist_pass), 32'd0);
    fault_sel = 2'b00; m_fault = 2'b00;
`endif

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
